// File: rtl/if_pkg.sv
// Shared constants and types for the MIPS instruction-fetch stage.
package if_pkg;

  // Instruction loaded into IF/ID whenever it carries no real instruction.
  localparam logic [31:0] NOP_INSN = 32'h0000_0000;

  // Default first fetch address after reset.
  localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;

  // Sequential PC step (one 32-bit word).
  localparam int unsigned PC_INC = 4;

  // FETCH: normal operation.
  // DRAIN: a redirect arrived while a fetch was outstanding; the returning word is dropped.
  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } if_state_e;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory request/ready handshake between the fetch stage and imem.
interface if_stage_if #(
  parameter int ADDR_W = 32,
  parameter int INSN_W = 32
);

  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              ready;
  logic [INSN_W-1:0] rdata;

  // Fetch stage side.
  modport master (output req, output addr, input ready, input rdata);

  // Memory side.
  modport slave (input req, input addr, output ready, output rdata);

endinterface

// File: rtl/if_skid_buf.sv
// One-entry buffer holding a fetched {pc, instr} pair while IF/ID cannot accept it.
module if_skid_buf
  import if_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int INSN_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              clear_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [INSN_W-1:0] instr_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic [INSN_W-1:0] instr_o
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INSN_W-1:0] instr_q, instr_d;

  // Next entry: clear beats push, a same-cycle push refills a popped entry.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (clear_i) begin
      valid_d = 1'b0;
    end else if (push_i) begin
      valid_d = 1'b1;
      pc_d    = pc_i;
      instr_d = instr_i;
    end else if (pop_i) begin
      valid_d = 1'b0;
    end
  end

  // Entry registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= INSN_W'(NOP_INSN);
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/if_stage.sv
// MIPS fetch stage: PC, imem handshake, skid buffer and IF/ID register.
module if_stage
  import if_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INSN_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_pc_keep,
  input  logic              i_IF_ID_keep,
  input  logic              i_IF_ID_flush,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  if_stage_if.master        imem,
  output logic              o_IF_ID_valid,
  output logic [ADDR_W-1:0] o_IF_ID_pc,
  output logic [ADDR_W-1:0] o_IF_ID_pc4,
  output logic [INSN_W-1:0] o_IF_ID_instr,
  output logic              o_fetch_stall
);

  if_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pend_q, pend_d;
  logic              in_flight_q, in_flight_d;

  logic              ifid_valid_q, ifid_valid_d;
  logic [ADDR_W-1:0] ifid_pc_q, ifid_pc_d;
  logic [ADDR_W-1:0] ifid_pc4_q, ifid_pc4_d;
  logic [INSN_W-1:0] ifid_instr_q, ifid_instr_d;

  logic              skid_valid;
  logic [ADDR_W-1:0] skid_pc;
  logic [INSN_W-1:0] skid_instr;

  logic req, outstanding, accept, loadable, fresh_to_ifid;
  logic skid_push, skid_pop, skid_clear;

  // Request is masked while reset is low so nothing is issued before release.
  assign req = reset && (state_q == FETCH) &&
               (in_flight_q || (!skid_valid && !i_pc_keep));
  // A request seen by memory but not answered this cycle.
  assign outstanding   = req && !imem.ready;
  assign accept        = (state_q == FETCH) && req && imem.ready && !i_redirect;
  assign loadable      = !i_IF_ID_keep || i_IF_ID_flush;
  assign fresh_to_ifid = accept && loadable && !skid_valid;
  assign skid_push     = accept && !fresh_to_ifid;
  assign skid_pop      = !i_IF_ID_flush && !i_IF_ID_keep && skid_valid && !i_redirect;
  assign skid_clear    = i_redirect;

  if_skid_buf #(
    .ADDR_W(ADDR_W),
    .INSN_W(INSN_W)
  ) u_skid (
    .clk    (clk),
    .reset  (reset),
    .push_i (skid_push),
    .pop_i  (skid_pop),
    .clear_i(skid_clear),
    .pc_i   (pc_q),
    .instr_i(imem.rdata),
    .valid_o(skid_valid),
    .pc_o   (skid_pc),
    .instr_o(skid_instr)
  );

  // PC / redirect FSM: redirects on an unanswered request are parked until the word returns.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_d      = pend_q;
    in_flight_d = in_flight_q;
    case (state_q)
      FETCH: begin
        in_flight_d = outstanding;
        if (i_redirect) begin
          if (outstanding) begin
            pend_d  = i_redirect_pc;
            state_d = DRAIN;
          end else begin
            pc_d = i_redirect_pc;
          end
        end else if (accept) begin
          pc_d = pc_q + ADDR_W'(PC_INC);
        end
      end
      DRAIN: begin
        in_flight_d = !imem.ready;
        if (i_redirect) pend_d = i_redirect_pc;
        if (imem.ready) begin
          pc_d    = i_redirect ? i_redirect_pc : pend_q;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // IF/ID next value: flush > keep > skid entry > fresh word > bubble.
  always_comb begin
    ifid_valid_d = ifid_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_instr_d = ifid_instr_q;
    if (i_IF_ID_flush) begin
      ifid_valid_d = 1'b0;
      ifid_instr_d = INSN_W'(NOP_INSN);
    end else if (i_IF_ID_keep) begin
      ifid_valid_d = ifid_valid_q;
    end else if (skid_valid && !i_redirect) begin
      ifid_valid_d = 1'b1;
      ifid_pc_d    = skid_pc;
      ifid_pc4_d   = skid_pc + ADDR_W'(PC_INC);
      ifid_instr_d = skid_instr;
    end else if (accept) begin
      ifid_valid_d = 1'b1;
      ifid_pc_d    = pc_q;
      ifid_pc4_d   = pc_q + ADDR_W'(PC_INC);
      ifid_instr_d = imem.rdata;
    end else begin
      ifid_valid_d = 1'b0;
      ifid_instr_d = INSN_W'(NOP_INSN);
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      pend_q      <= '0;
      in_flight_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_q      <= pend_d;
      in_flight_q <= in_flight_d;
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_pc4_q   <= '0;
      ifid_instr_q <= INSN_W'(NOP_INSN);
    end else begin
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_instr_q <= ifid_instr_d;
    end
  end

  assign imem.req      = req;
  assign imem.addr     = pc_q;
  assign o_fetch_stall = outstanding;
  assign o_IF_ID_valid = ifid_valid_q;
  assign o_IF_ID_pc    = ifid_pc_q;
  assign o_IF_ID_pc4   = ifid_pc4_q;
  assign o_IF_ID_instr = ifid_instr_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed per-cycle table, async reset sequence, randomized run.
module tb_if_stage;

  localparam logic [31:0] P = 32'h0040_0000;

  logic        clk        = 1'b0;
  logic        reset      = 1'b0;
  logic        pc_keep    = 1'b0;
  logic        ifid_keep  = 1'b0;
  logic        ifid_flush = 1'b0;
  logic        redirect   = 1'b0;
  logic [31:0] rpc        = 32'h0;
  logic        id_valid;
  logic [31:0] id_pc, id_pc4, id_instr;
  logic        stall;

  if_stage_if #(.ADDR_W(32), .INSN_W(32)) imem ();

  if_stage #(.ADDR_W(32), .INSN_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_pc_keep    (pc_keep),
    .i_IF_ID_keep (ifid_keep),
    .i_IF_ID_flush(ifid_flush),
    .i_redirect   (redirect),
    .i_redirect_pc(rpc),
    .imem         (imem),
    .o_IF_ID_valid(id_valid),
    .o_IF_ID_pc   (id_pc),
    .o_IF_ID_pc4  (id_pc4),
    .o_IF_ID_instr(id_instr),
    .o_fetch_stall(stall)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Memory contents: low bit forced to 1 so no aligned address reads as NOP.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hC0DE_0001;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        rst_n, rdy, pck, kp, fl, rd;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        stall, vld;
    logic [31:0] pc, pc4, ins;
  } vec_t;

  function automatic vec_t mk(input logic rst_n, rdy, pck, kp, fl, rd, input logic [31:0] r_pc,
                              input logic e_req, input logic [31:0] e_addr, input logic e_stall,
                              input logic e_vld, input logic [31:0] e_pc, e_pc4, e_ins);
    vec_t v;
    v.rst_n = rst_n; v.rdy = rdy; v.pck = pck; v.kp = kp; v.fl = fl; v.rd = rd; v.rpc = r_pc;
    v.req = e_req; v.addr = e_addr; v.stall = e_stall;
    v.vld = e_vld; v.pc = e_pc; v.pc4 = e_pc4; v.ins = e_ins;
    return v;
  endfunction

  vec_t tbl[26];

  // Random-phase state.
  logic [31:0] exp_pc, mem_addr;
  logic        mem_busy, hold_req;
  int          mem_cnt, consumed;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    imem.ready = 1'b0;
    imem.rdata = 32'h0;

    //           rst rdy pck kp fl rd rpc          req addr         stl vld pc            pc4           instr
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 32'h0,          0, P,           0,  0, 32'h0,        32'h0,        32'h0);
    tbl[1]  = mk(1, 1, 0, 0, 0, 0, 32'h0,          1, P,           0,  0, 32'h0,        32'h0,        32'h0);
    tbl[2]  = mk(1, 1, 0, 0, 0, 0, 32'h0,          1, P+4,         0,  1, P,            P+4,          memf(P));
    tbl[3]  = mk(1, 1, 0, 0, 0, 0, 32'h0,          1, P+8,         0,  1, P+4,          P+8,          memf(P+4));
    tbl[4]  = mk(1, 0, 0, 0, 0, 0, 32'h0,          1, P+'hC,       1,  1, P+8,          P+'hC,        memf(P+8));
    tbl[5]  = mk(1, 0, 0, 0, 0, 0, 32'h0,          1, P+'hC,       1,  0, P+8,          P+'hC,        32'h0);
    tbl[6]  = mk(1, 0, 0, 0, 0, 0, 32'h0,          1, P+'hC,       1,  0, P+8,          P+'hC,        32'h0);
    tbl[7]  = mk(1, 1, 0, 0, 0, 0, 32'h0,          1, P+'hC,       0,  0, P+8,          P+'hC,        32'h0);
    tbl[8]  = mk(1, 0, 0, 0, 0, 0, 32'h0,          1, P+'h10,      1,  1, P+'hC,        P+'h10,       memf(P+'hC));
    tbl[9]  = mk(1, 1, 1, 1, 0, 0, 32'h0,          1, P+'h10,      0,  0, P+'hC,        P+'h10,       32'h0);
    tbl[10] = mk(1, 1, 1, 1, 0, 0, 32'h0,          0, P+'h14,      0,  0, P+'hC,        P+'h10,       32'h0);
    tbl[11] = mk(1, 1, 0, 0, 0, 0, 32'h0,          0, P+'h14,      0,  0, P+'hC,        P+'h10,       32'h0);
    tbl[12] = mk(1, 1, 0, 0, 0, 0, 32'h0,          1, P+'h14,      0,  1, P+'h10,       P+'h14,       memf(P+'h10));
    tbl[13] = mk(1, 0, 0, 0, 0, 0, 32'h0,          1, P+'h18,      1,  1, P+'h14,       P+'h18,       memf(P+'h14));
    tbl[14] = mk(1, 0, 0, 0, 1, 1, P+'h100,        1, P+'h18,      1,  0, P+'h14,       P+'h18,       32'h0);
    tbl[15] = mk(1, 0, 0, 0, 0, 0, 32'h0,          0, P+'h18,      0,  0, P+'h14,       P+'h18,       32'h0);
    tbl[16] = mk(1, 1, 0, 0, 0, 0, 32'h0,          0, P+'h18,      0,  0, P+'h14,       P+'h18,       32'h0);
    tbl[17] = mk(1, 1, 0, 0, 0, 0, 32'h0,          1, P+'h100,     0,  0, P+'h14,       P+'h18,       32'h0);
    tbl[18] = mk(1, 1, 0, 0, 0, 0, 32'h0,          1, P+'h104,     0,  1, P+'h100,      P+'h104,      memf(P+'h100));
    tbl[19] = mk(1, 1, 0, 1, 0, 0, 32'h0,          1, P+'h108,     0,  1, P+'h104,      P+'h108,      memf(P+'h104));
    tbl[20] = mk(1, 1, 0, 1, 1, 1, P+'h200,        0, P+'h10C,     0,  1, P+'h104,      P+'h108,      memf(P+'h104));
    tbl[21] = mk(1, 1, 0, 0, 0, 0, 32'h0,          1, P+'h200,     0,  0, P+'h104,      P+'h108,      32'h0);
    tbl[22] = mk(1, 1, 0, 0, 1, 1, 32'hFFFF_FFFC,  1, P+'h204,     0,  1, P+'h200,      P+'h204,      memf(P+'h200));
    tbl[23] = mk(1, 1, 0, 0, 0, 0, 32'h0,          1, 32'hFFFF_FFFC,0, 0, P+'h200,      P+'h204,      32'h0);
    tbl[24] = mk(1, 1, 0, 0, 0, 0, 32'h0,          1, 32'h0,       0,  1, 32'hFFFF_FFFC,32'h0,        memf(32'hFFFF_FFFC));
    tbl[25] = mk(1, 0, 0, 0, 0, 0, 32'h0,          1, 32'h4,       1,  1, 32'h0,        32'h4,        memf(32'h0));

    // Directed per-cycle table.
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      reset      = tbl[i].rst_n;
      imem.ready = tbl[i].rdy;
      pc_keep    = tbl[i].pck;
      ifid_keep  = tbl[i].kp;
      ifid_flush = tbl[i].fl;
      redirect   = tbl[i].rd;
      rpc        = tbl[i].rpc;
      #1;
      imem.rdata = memf(imem.addr);
      #1;
      chk($sformatf("row%0d_req", i),   {31'b0, imem.req}, {31'b0, tbl[i].req});
      chk($sformatf("row%0d_addr", i),  imem.addr,         tbl[i].addr);
      chk($sformatf("row%0d_stall", i), {31'b0, stall},    {31'b0, tbl[i].stall});
      chk($sformatf("row%0d_valid", i), {31'b0, id_valid}, {31'b0, tbl[i].vld});
      chk($sformatf("row%0d_pc", i),    id_pc,             tbl[i].pc);
      chk($sformatf("row%0d_pc4", i),   id_pc4,            tbl[i].pc4);
      chk($sformatf("row%0d_instr", i), id_instr,          tbl[i].ins);
    end

    // Reset asserted mid-handshake: fetch of 0x4 is outstanding, its word returns during reset.
    @(negedge clk);
    pc_keep = 1'b0; ifid_keep = 1'b0; ifid_flush = 1'b0; redirect = 1'b0;
    imem.ready = 1'b1;
    imem.rdata = memf(32'h4);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_mid_req",   {31'b0, imem.req}, 32'h0);
    chk("rst_mid_addr",  imem.addr,         P);
    chk("rst_mid_stall", {31'b0, stall},    32'h0);
    chk("rst_mid_valid", {31'b0, id_valid}, 32'h0);
    chk("rst_mid_pc",    id_pc,             32'h0);
    chk("rst_mid_pc4",   id_pc4,            32'h0);
    chk("rst_mid_instr", id_instr,          32'h0);
    @(negedge clk);
    imem.ready = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst_rel_req",   {31'b0, imem.req}, 32'h1);
    chk("rst_rel_addr",  imem.addr,         P);
    chk("rst_rel_stall", {31'b0, stall},    32'h1);
    @(negedge clk);
    imem.ready = 1'b1;
    #1;
    imem.rdata = memf(imem.addr);
    #1;
    chk("rst_rel2_addr",  imem.addr,         P);
    chk("rst_rel2_valid", {31'b0, id_valid}, 32'h0);
    @(negedge clk);
    imem.ready = 1'b0;
    #2;
    chk("rst_first_valid", {31'b0, id_valid}, 32'h1);
    chk("rst_first_pc",    id_pc,             P);
    chk("rst_first_instr", id_instr,          memf(P));

    // Randomized run against a program-order reference model.
    @(negedge clk);
    reset = 1'b0;
    imem.ready = 1'b0;
    @(negedge clk);
    reset    = 1'b1;
    exp_pc   = P;
    mem_busy = 1'b0;
    mem_addr = 32'h0;
    mem_cnt  = 0;
    hold_req = 1'b0;
    consumed = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc > 0) @(negedge clk);
      pc_keep    = ($urandom_range(0, 99) < 20);
      ifid_keep  = ($urandom_range(0, 99) < 20);
      redirect   = ($urandom_range(0, 99) < 5);
      ifid_flush = redirect;
      rpc        = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF8
                                                : P + (32'($urandom_range(0, 255)) << 2);
      #1;
      if (mem_busy && imem.req) chk("rnd_addr_hold", imem.addr, mem_addr);
      if (hold_req) chk("rnd_req_hold", {31'b0, imem.req}, 32'h1);
      if (!mem_busy && imem.req) begin
        mem_busy = 1'b1;
        mem_addr = imem.addr;
        mem_cnt  = $urandom_range(0, 3);
      end
      imem.ready = mem_busy && (mem_cnt == 0);
      imem.rdata = imem.ready ? memf(mem_addr) : 32'hBAD0_BAD0;
      #1;
      chk("rnd_stall", {31'b0, stall}, {31'b0, imem.req && !imem.ready});
      if (!id_valid) chk("rnd_bubble_nop", id_instr, 32'h0);
      if (id_valid && !ifid_keep && !ifid_flush) begin
        chk("rnd_order_pc", id_pc,    exp_pc);
        chk("rnd_instr",    id_instr, memf(id_pc));
        chk("rnd_pc4",      id_pc4,   id_pc + 32'd4);
        exp_pc   = exp_pc + 32'd4;
        consumed = consumed + 1;
      end
      if (redirect) exp_pc = rpc;
      hold_req = imem.req && !imem.ready && !redirect;
      if (mem_busy) begin
        if (imem.ready) mem_busy = 1'b0;
        else mem_cnt = mem_cnt - 1;
      end
    end
    chk("rnd_progress", {31'b0, (consumed >= 100)}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
